// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-boundary registers: state encoding, occupancy
// constants and the default EX/MEM field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd1;
  localparam logic [1:0] OCC_SKID  = 2'd2;

  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam int unsigned EXMEM_DATA_W = 202;

  function automatic logic [1:0] state_occ(pipe_state_e st);
    logic [1:0] occ;
    case (st)
      ST_FULL: occ = OCC_FULL;
      ST_SKID: occ = OCC_SKID;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline boundary: control + payload register with load
// enable, synchronous active-low clear and a payload-only clear.
module pipe_slot #(
  parameter int unsigned CtrlW = 8,
  parameter int unsigned DataW = 202
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_data_i,
  input  logic [CtrlW-1:0] ctrl_i,
  input  logic [DataW-1:0] data_i,
  output logic [CtrlW-1:0] ctrl_o,
  output logic [DataW-1:0] data_o
);

  logic [CtrlW-1:0] ctrl_q;
  logic [DataW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      if (load_i) begin
        ctrl_q <= ctrl_i;
      end
      if (clr_data_i) begin
        data_q <= '0;
      end else if (load_i) begin
        data_q <= data_i;
      end
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake and a 2-entry skid buffer;
// in_ready depends only on registered state, and flush turns entries into bubbles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W            = EXMEM_CTRL_W,
  parameter int unsigned DATA_W            = EXMEM_DATA_W,
  parameter bit          FLUSH_CLEARS_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  pipe_state_e state_q, state_d;

  logic              accept, drain, clr_data;
  logic              main_load, main_from_skid, skid_load;
  logic [CTRL_W-1:0] main_ctrl_d, main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data_d, main_data, skid_data;

  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign count     = state_occ(state_q);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign clr_data  = flush & FLUSH_CLEARS_DATA;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main refills from the skid slot when draining out of SKID, else from upstream.
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;

  pipe_slot #(
    .CtrlW (CTRL_W),
    .DataW (DATA_W)
  ) u_main (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (main_load),
    .clr_data_i (clr_data),
    .ctrl_i     (main_ctrl_d),
    .data_i     (main_data_d),
    .ctrl_o     (main_ctrl),
    .data_o     (main_data)
  );

  pipe_slot #(
    .CtrlW (CTRL_W),
    .DataW (DATA_W)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (skid_load),
    .clr_data_i (clr_data),
    .ctrl_i     (in_ctrl),
    .data_i     (in_data),
    .ctrl_o     (skid_ctrl),
    .data_o     (skid_data)
  );

  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a 2-deep FIFO reference model predicts
// occupancy and output order; a negedge monitor checks everything the DUT presents.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 202;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    count;

  pipe_stage_reg #(
    .CTRL_W            (CW),
    .DATA_W            (DW),
    .FLUSH_CLEARS_DATA (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  ent_t src_q[$];  // upstream entries waiting to be offered
  ent_t sb_q[$];   // accepted entries, in expected output order
  int   occ      = 0;
  bit   zeroed   = 1'b1;
  bit   mon_en   = 1'b0;
  int   vectors  = 0;
  int   fails    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 256'(count), 256'(occ));
      chk("out_valid", 256'(out_valid), 256'(occ > 0));
      chk("in_ready", 256'(in_ready), 256'(occ < 2));
      if (occ == 0) chk("bubble_ctrl", 256'(out_ctrl), 256'(0));
      if (occ == 0 && zeroed) chk("zero_data", 256'(out_data), 256'(0));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_nonempty", 256'(0), 256'(1));
        end else begin
          ent_t e;
          e = sb_q.pop_front();
          chk("out_ctrl", 256'(out_ctrl), 256'(e.ctrl));
          chk("out_data", 256'(out_data), 256'(e.data));
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 7; i++) d = (d << 32) | DW'($urandom);
    return d;
  endfunction

  task automatic push_src(input logic [DW-1:0] d);
    ent_t e;
    e.ctrl = CW'($urandom);
    e.data = d;
    src_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then advance the reference model at the edge.
  task automatic step(input bit r, input bit f, input bit ordy, input bit offer);
    bit offered, acc, drn;
    reset     = r;
    flush     = f;
    out_ready = ordy;
    offered   = offer && (src_q.size() > 0);
    if (offered) begin
      in_valid = 1'b1;
      in_ctrl  = src_q[0].ctrl;
      in_data  = src_q[0].data;
    end else begin
      in_valid = 1'b0;
      in_ctrl  = CW'($urandom);
      in_data  = rand_data();
    end
    @(posedge clk);
    acc = r && !f && offered && (occ < 2);
    drn = (occ > 0) && ordy;
    if (!r || f) begin
      if (offered) void'(src_q.pop_front());
      sb_q.delete();
      occ    = 0;
      zeroed = 1'b1;
    end else begin
      if (drn) occ--;
      if (acc) begin
        sb_q.push_back(src_q.pop_front());
        occ++;
        zeroed = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    // Reset held with a live upstream entry carrying all-ones control.
    src_q.push_back('{ctrl: 8'hFF, data: rand_data()});
    step(1'b0, 1'b0, 1'b1, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    src_q.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Streaming 1..10 back-to-back.
    for (int i = 1; i <= 10; i++) push_src(DW'(i));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // Back-pressure for one cycle while entry 1 is presented.
    for (int i = 1; i <= 3; i++) push_src(DW'(i));
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // Flush while in SKID with entry 9 offered.
    push_src(DW'(20));
    push_src(DW'(21));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    src_q.delete();
    push_src(DW'(9));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    // Simultaneous accept and drain in FULL.
    push_src(DW'(5));
    push_src(DW'(6));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // Reset while in SKID.
    push_src(DW'(30));
    push_src(DW'(31));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      if (src_q.size() < 3 && $urandom_range(0, 3) != 0) push_src(rand_data());
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    // Drain whatever remains.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sb_left", 256'(sb_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-boundary register with valid/ready handshake, 2-entry skid buffer, synchronous flush and control-field squashing. It is the generalised replacement for fixed per-stage registers such as the EX/MEM boundary, and sits between any two pipeline stages of the RISC-V core. Downstream back-pressure is absorbed without a combinational ready path. A flush converts in-flight entries into bubbles whose control bits read as zero.

## Interface
Parameters:
- CTRL_W, 8: width of the control field (Branch, MemRead, MemWrite, MemtoReg, RegWrite, …); forced to zero whenever the output is not valid.
- DATA_W, 202: width of the payload (RD, PC-target, ALU result, store data, …); never squashed.
- FLUSH_CLEARS_DATA, 0: 1 means a flush also zeroes both payload slots; 0 means payload holds its last value.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-low. Sampled on the clk rising edge; 0 resets the block.
- flush, input, 1: synchronous flush; discards all stored entries.
- in_valid, input, 1: upstream entry present.
- in_ready, output, 1: block can accept this cycle.
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: control field. Equals the main slot's control when out_valid=1, otherwise 0.
- out_data, output, DATA_W: payload of the main slot.
- count, output, 2: occupancy, 0–2.

## Operation
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- State register has three states:
  - EMPTY: count=0, out_valid=0, in_ready=1.
  - FULL: count=1, out_valid=1, in_ready=1.
  - SKID: count=2, out_valid=1, in_ready=0.
- Transitions, in priority order reset > flush > handshake:
  - EMPTY: accept → FULL, main←in. Otherwise stay.
  - FULL, accept & drain: stay FULL, main←in.
  - FULL, accept & !drain: → SKID, skid←in, main held.
  - FULL, !accept & drain: → EMPTY.
  - FULL, neither: hold.
  - SKID: drain → FULL, main←skid. Otherwise hold. No accept is possible.
- flush=1: next state EMPTY, regardless of accept or drain.
  - An input presented in the flush cycle is discarded.
  - A drain in the flush cycle counts as completed; the consumer keeps that entry.
  - Payload slots are zeroed only if FLUSH_CLEARS_DATA=1.
- Reset (reset=0 at an edge): state EMPTY; main and skid slots (ctrl and data) all 0. Resulting outputs:
  - out_valid=0, out_ctrl=0, out_data=0, count=0, in_ready=1.
  - Reset mid-operation drops all entries, including a pending skid entry.
- in_valid asserted while in_ready=0 is ignored. Upstream must hold its entry until accepted.
- out_data is stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO: the skid entry is never presented before the main entry.

## Timing
- Latency: accept at edge N → out_valid=1 with that entry after edge N, i.e. visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1. Skid is never entered in steady state.
- in_ready is a decode of the state register only. There is no combinational path from out_ready or in_valid.
- out_valid, out_data and count are register decodes. out_ctrl is the main-slot control AND-gated with out_valid.
- After out_ready drops for one cycle during streaming: the block enters SKID, in_ready=0 for the following cycle, then recovers to FULL on the next drain.
- flush and reset both take effect at the same edge they are sampled; outputs are bubbles in the following cycle.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - the occupancy constants;
  - the default CTRL_W/DATA_W for the EX/MEM use.
- One sub-module: pipe_slot.
  - CTRL_W+DATA_W load-enable register with synchronous active-low clear and a data-clear input.
  - Instantiated twice, as main and skid.
- The state machine and handshake decode live in pipe_stage_reg.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 and in_ctrl=8'hFF.
  - During and after: out_valid=0, out_ctrl=0, out_data=0, count=0, in_ready=1.
- Streaming: 10 back-to-back entries, data=1..10, out_ready=1.
  - Outputs 1..10 in order, one per cycle, first one cycle after its accept.
  - count never exceeds 1.
- Back-pressure: stream data=1,2,3 and drop out_ready for the cycle when 1 is presented.
  - count=2 and in_ready=0 next cycle; 3 is held off.
  - Output order 1,2,3; no loss or duplication.
- Flush in SKID: flush=1 with in_valid=1 (data=9) in the cycle after count=2.
  - Next cycle: out_valid=0, out_ctrl=0, count=0.
  - Entry 9 never appears.
  - With FLUSH_CLEARS_DATA=1, out_data=0.
- Simultaneous accept+drain in FULL with data=5 presented and 6 incoming.
  - 5 transfers, 6 appears the next cycle, count stays 1.
- Reset mid-SKID: reset=0 with count=2.
  - Next cycle is fully reset; the skid entry is never output after release.
